// File: rtl/credit_tx.sv
// credit_tx: transmit side of a credit-based FIFO link.
// A single-entry hold register sits between the local producer (valid/ready)
// and the remote receiver. A word is forwarded only while a credit is held.
// The credit counter mirrors the receiver's free slots and is topped up by
// credit-return pulses. A drain sequence lets software wait until the hold
// register is empty and every credit has come home.
module credit_tx #(
  parameter int DATA_WIDTH  = 32,
  parameter int MAX_CREDITS = 8,
  localparam int CNT_W      = $clog2(MAX_CREDITS + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  tx_valid,
  output logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  cr_return_valid,
  input  logic [CNT_W-1:0]      cr_return_count,
  output logic [CNT_W-1:0]      credits_avail,
  input  logic                  drain_req,
  output logic                  drain_done,
  output logic                  cr_overflow
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_CREDITS);
  localparam logic [CNT_W:0]   MAX_EXT = (CNT_W + 1)'(MAX_CREDITS);

  typedef enum logic [1:0] {
    ST_INIT,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } state_t;

  state_t                state;
  logic [CNT_W-1:0]      credits;
  logic                  hold_valid;
  logic [DATA_WIDTH-1:0] hold_data;

  logic                  credit_ok;
  logic                  accept;
  logic                  send;
  logic [CNT_W:0]        ret_ext;
  logic [CNT_W:0]        credits_next;

  assign credits_avail = credits;

  // Handshake, send decision and next credit count, all from registered state.
  // Sends look only at the registered count so a same-cycle return never
  // enables a send.
  always_comb begin
    credit_ok    = (credits != '0);
    s_ready      = (state == ST_RUN) && !drain_req && (!hold_valid || credit_ok);
    accept       = s_valid && s_ready;
    send         = hold_valid && credit_ok;
    ret_ext      = cr_return_valid ? {1'b0, cr_return_count} : '0;
    credits_next = {1'b0, credits} - {{CNT_W{1'b0}}, send} + ret_ext;
  end

  // Link state machine, hold register, credit counter and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ST_INIT;
      credits     <= '0;
      hold_valid  <= 1'b0;
      hold_data   <= '0;
      tx_valid    <= 1'b0;
      tx_data     <= '0;
      drain_done  <= 1'b0;
      cr_overflow <= 1'b0;
    end else begin
      // One-cycle hold-to-tx latency; tx_data keeps its last value when idle.
      tx_valid <= send;
      if (send) begin
        tx_data <= hold_data;
      end

      // Accept and send in the same cycle simply replace the hold word.
      if (accept) begin
        hold_valid <= 1'b1;
        hold_data  <= s_data;
      end else if (send) begin
        hold_valid <= 1'b0;
      end

      // Credits are loaded in INIT; any nonzero return there is an error.
      if (state == ST_INIT) begin
        credits <= MAX_CNT;
        if (cr_return_valid && (cr_return_count != '0)) begin
          cr_overflow <= 1'b1;
        end
      end else if (credits_next > MAX_EXT) begin
        credits     <= MAX_CNT;
        cr_overflow <= 1'b1;
      end else begin
        credits <= credits_next[CNT_W-1:0];
      end

      case (state)
        ST_INIT: begin
          state <= ST_RUN;
        end
        ST_RUN: begin
          if (drain_req) begin
            state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (!drain_req) begin
            state <= ST_RUN;
          end else if (!hold_valid && (credits == MAX_CNT)) begin
            state      <= ST_DONE;
            drain_done <= 1'b1;
          end
        end
        ST_DONE: begin
          if (!drain_req) begin
            state      <= ST_RUN;
            drain_done <= 1'b0;
          end
        end
        default: begin
          state <= ST_INIT;
        end
      endcase
    end
  end

endmodule
